// File: rtl/int_to_fp_sp_if.sv
// Handshake bundle for int_to_fp_sp: operand side (i_VALID/o_READY/i_A/i_SIGNED)
// and result side (o_VALID/i_READY/o_RES).
interface int_to_fp_sp_if;
  logic        i_VALID;
  logic        o_READY;
  logic [31:0] i_A;
  logic        i_SIGNED;
  logic        o_VALID;
  logic        i_READY;
  logic [31:0] o_RES;

  modport master (
    output i_VALID, i_A, i_SIGNED, i_READY,
    input  o_READY, o_VALID, o_RES
  );

  modport slave (
    input  i_VALID, i_A, i_SIGNED, i_READY,
    output o_READY, o_VALID, o_RES
  );
endinterface

// File: rtl/int_to_fp_sp.sv
// int_to_fp_sp: multi-cycle 32-bit integer -> IEEE-754 single converter.
// Iterative leading-zero normaliser (NORM_STEP bits per skip), then RNE rounding.
// Optional: define INT_TO_FP_INEXACT_EN to add the o_INEXACT output.
module int_to_fp_sp #(
  parameter int NORM_STEP = 4
) (
  input  logic           i_CLK,
  input  logic           i_RST_N,
  int_to_fp_sp_if.slave  bus
`ifdef INT_TO_FP_INEXACT_EN
  ,
  output logic           o_INEXACT
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  localparam logic [5:0] STEP_W = 6'(NORM_STEP);

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        valid_q, valid_d;
`ifdef INT_TO_FP_INEXACT_EN
  logic        inex_q, inex_d;
`endif

  logic [31:0] abs_a;
  logic        grd, stk, rup;
  logic [23:0] mant_w;
  logic [7:0]  exp_w;

  assign bus.o_READY = (state_q == S_IDLE);
  assign bus.o_VALID = valid_q;
  assign bus.o_RES   = res_q;
`ifdef INT_TO_FP_INEXACT_EN
  assign o_INEXACT   = inex_q;
`endif

  // Next-state and datapath update for the accept/normalise/round/hold sequence.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    valid_d = valid_q;
`ifdef INT_TO_FP_INEXACT_EN
    inex_d  = inex_q;
`endif

    abs_a  = (bus.i_SIGNED && bus.i_A[31]) ? (~bus.i_A + 32'd1) : bus.i_A;
    grd    = mag_q[7];
    stk    = |mag_q[6:0];
    rup    = grd & (stk | mag_q[8]);
    // Bit 23 of mant_w is the rounding carry; bits [22:0] are already zero then.
    mant_w = {1'b0, mag_q[30:8]} + {23'b0, rup};
    exp_w  = 8'd158 - {2'b00, cnt_q} + {7'b0, mant_w[23]};

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_VALID) begin
          sign_d = bus.i_SIGNED & bus.i_A[31];
          mag_d  = abs_a;
          cnt_d  = '0;
          if (abs_a == '0) begin
            res_d   = '0;
            valid_d = 1'b1;
`ifdef INT_TO_FP_INEXACT_EN
            inex_d  = 1'b0;
`endif
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (mag_q[31]) begin
          state_d = S_ROUND;
        end else if (mag_q[31 -: NORM_STEP] == '0) begin
          mag_d = mag_q << NORM_STEP;
          cnt_d = cnt_q + STEP_W;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_ROUND: begin
        res_d   = {sign_q, exp_w, mant_w[22:0]};
        valid_d = 1'b1;
`ifdef INT_TO_FP_INEXACT_EN
        inex_d  = grd | stk;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.i_READY) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      sign_q  <= 1'b0;
      mag_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
`ifdef INT_TO_FP_INEXACT_EN
      inex_q  <= 1'b0;
`endif
    end else begin
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      valid_q <= valid_d;
`ifdef INT_TO_FP_INEXACT_EN
      inex_q  <= inex_d;
`endif
    end
  end

endmodule
